// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two valid/ready requesters; optional ALU_DIV0_GUARD_EN short-circuits divide-by-zero
module alu_share_arbiter #(
   parameter int WIDTH       = 32,
   parameter int EXEC_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req0_op1,
   input  logic [WIDTH-1:0] req0_op2,
   input  logic [2:0]       req0_sel,
   input  logic [WIDTH-1:0] req1_op1,
   input  logic [WIDTH-1:0] req1_op2,
   input  logic [2:0]       req1_sel,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zflag,
   output logic             rsp_err,
   output logic [WIDTH-1:0] alu_op1,
   output logic [WIDTH-1:0] alu_op2,
   output logic [2:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zflag
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t           state_q, state_d;
   logic             prio_q, prio_d, gnt_q, gnt_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] alu_op1_q, alu_op1_d, alu_op2_q, alu_op2_d;
   logic [2:0]       alu_sel_q, alu_sel_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_zflag_q, rsp_zflag_d, rsp_err_q, rsp_err_d;
   logic             any, g, div0;
   logic [WIDTH-1:0] op1_g, op2_g;
   logic [2:0]       sel_g;
   // grant candidate: the sole requester, or prio when both are asking
   always_comb begin
      any   = |req_valid;
      g     = &req_valid ? prio_q : req_valid[1];
      op1_g = g ? req1_op1 : req0_op1;
      op2_g = g ? req1_op2 : req0_op2;
      sel_g = g ? req1_sel : req0_sel;
   end
`ifdef ALU_DIV0_GUARD_EN
   assign div0 = (sel_g == 3'b100) && (op2_g == '0);
`else
   assign div0 = 1'b0;
`endif
   assign req_ready  = (state_q == IDLE && any) ? (g ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_valid  = (state_q == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_result = rsp_result_q;
   assign rsp_zflag  = rsp_zflag_q;
   assign rsp_err    = rsp_err_q;
   assign alu_op1    = alu_op1_q;
   assign alu_op2    = alu_op2_q;
   assign alu_sel    = alu_sel_q;
   // next-state: accept in IDLE, count settle window in EXEC, hold response until handshake
   always_comb begin
      state_d      = state_q;
      prio_d       = prio_q;
      gnt_d        = gnt_q;
      cnt_d        = cnt_q;
      alu_op1_d    = alu_op1_q;
      alu_op2_d    = alu_op2_q;
      alu_sel_d    = alu_sel_q;
      rsp_result_d = rsp_result_q;
      rsp_zflag_d  = rsp_zflag_q;
      rsp_err_d    = rsp_err_q;
      case (state_q)
         IDLE: if (any) begin
            gnt_d  = g;
            prio_d = ~g;
            cnt_d  = 4'(EXEC_CYCLES - 1);
            if (div0) begin
               state_d      = RESP;
               rsp_result_d = '1;
               rsp_zflag_d  = 1'b1;
               rsp_err_d    = 1'b1;
            end else begin
               state_d   = EXEC;
               alu_op1_d = op1_g;
               alu_op2_d = op2_g;
               alu_sel_d = sel_g;
            end
         end
         EXEC: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
         else begin
            state_d      = RESP;
            rsp_result_d = alu_result;
            rsp_zflag_d  = alu_zflag;
            rsp_err_d    = 1'b0;
         end
         RESP: if (rsp_ready[gnt_q]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // state and output registers, cleared asynchronously so nothing in flight survives reset
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q      <= IDLE;
         prio_q       <= 1'b0;
         gnt_q        <= 1'b0;
         cnt_q        <= '0;
         alu_op1_q    <= '0;
         alu_op2_q    <= '0;
         alu_sel_q    <= '0;
         rsp_result_q <= '0;
         rsp_zflag_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         prio_q       <= prio_d;
         gnt_q        <= gnt_d;
         cnt_q        <= cnt_d;
         alu_op1_q    <= alu_op1_d;
         alu_op2_q    <= alu_op2_d;
         alu_sel_q    <= alu_sel_d;
         rsp_result_q <= rsp_result_d;
         rsp_zflag_q  <= rsp_zflag_d;
         rsp_err_q    <= rsp_err_d;
      end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU (3-bit op select, result plus zero-flag outputs) between two requesters, e.g. the datapath issue stage and the address/compare unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block grants round-robin, holds the operands stable on the ALU inputs for a programmable settle window, registers the result, and returns it to the granted requester.
- Only one operation is in flight at a time.

Parameters:
- WIDTH, 32, operand and result width; must match the ALU.
- EXEC_CYCLES, 1, cycles the operands are held on the ALU before the result is captured; legal range 1..15, so multiply/divide paths can settle.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  2  bit i: requester i presents an operation.
- req_ready  output  2  bit i: request i accepted this cycle.
- req0_op1, req0_op2  input  WIDTH each  operands from requester 0.
- req0_sel  input  3  ALU op from requester 0.
- req1_op1, req1_op2  input  WIDTH each  operands from requester 1.
- req1_sel  input  3  ALU op from requester 1.
- rsp_valid  output  2  bit i: response for requester i is valid.
- rsp_ready  input  2  bit i: requester i takes the response.
- rsp_result  output  WIDTH  registered ALU result, shared by both requesters.
- rsp_zflag  output  1  registered ALU zflag; 1 when the result is non-zero, matching the ALU's convention.
- rsp_err  output  1  divide-by-zero error; see Optional Feature.
- alu_op1, alu_op2  output  WIDTH each  to ALU operand inputs.
- alu_sel  output  3  to ALU select input.
- alu_result  input  WIDTH  from ALU.
- alu_zflag  input  1  from ALU.

Behaviour:
- Reset values: state=IDLE, prio=0, gnt=0, cnt=0, alu_op1/alu_op2/alu_sel=0, rsp_result=0, rsp_zflag=0, rsp_err=0, rsp_valid=0, req_ready=0.
- Reset is asynchronous and takes effect at any time, including mid-EXEC or mid-RESP. No pending response survives reset, and no request is considered accepted.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE, grant selection:
  - Only one valid request: grant it.
  - Both valid: grant index prio.
  - req_ready[g] is asserted combinationally in the same cycle, only in IDLE, only for g. The other bit stays 0.
- IDLE, acceptance edge:
  - Latch the selected op1/op2/sel into the alu_* output registers.
  - gnt<=g, prio<=~g, cnt<=EXEC_CYCLES-1, go to EXEC.
- IDLE, nothing valid: stay in IDLE; alu_* hold their last values.
- EXEC:
  - alu_* are held constant and req_ready=0.
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: rsp_result<=alu_result, rsp_zflag<=alu_zflag, rsp_err<=0, go to RESP.
- RESP:
  - rsp_valid[gnt]=1; the other bit is 0.
  - rsp_result, rsp_zflag and rsp_err are held stable until the handshake.
  - When rsp_ready[gnt]=1: go to IDLE. rsp_ready on the non-granted bit is ignored.
- Latency: acceptance at edge N; response valid from cycle N+EXEC_CYCLES+1. Minimum issue interval is EXEC_CYCLES+2 cycles.
- Requester-side rules:
  - A requester must hold req_valid and its operands stable until req_ready.
  - Deasserting req_valid before acceptance withdraws the request; no error.
- All 8 sel codes are forwarded unmodified. Width and overflow behaviour is the ALU's (truncated to WIDTH).
- A new request arriving during EXEC/RESP waits; it is never dropped.
- prio toggles only on a grant, so a sole requester can be granted back-to-back.

Optional Feature:
- Macro: ALU_DIV0_GUARD_EN.
- Defined:
  - In IDLE, an accepted request with sel==3'b100 and op2==0 skips EXEC and goes directly to RESP on the next edge.
  - The ALU is not driven with the new operands; alu_* keep their previous values.
  - rsp_result<=all ones, rsp_zflag<=1, rsp_err<=1.
  - prio and gnt update as for a normal grant.
- Undefined: no detection; divide-by-zero goes through EXEC and the ALU's result is returned. rsp_err is tied 0.

Test Plan:
- EXEC_CYCLES=1, reset released, req0 add 5+7 (sel 000), rsp_ready=1 -> req_ready=2'b01 at acceptance; rsp_valid=2'b01 two cycles later; rsp_result=12, rsp_zflag=1; FSM back in IDLE next cycle.
- req_valid=2'b11 from reset (req0: sub 9-9 sel 001; req1: slt 3<4 sel 010) -> req0 served first with result 0, zflag 0; then req1 with result 1, zflag 1; prio=0 after both.
- Only req1 valid for three back-to-back ops (or 0xF0 | 0x0F sel 110) -> all three granted to requester 1; each result 0xFF; issue interval exactly EXEC_CYCLES+2.
- EXEC_CYCLES=4, req0 mul 6*7 (sel 011), rsp_ready=0 for 5 cycles -> alu_* stable for 4 cycles; rsp_valid held with result 42 until rsp_ready; req1 arriving meanwhile gets req_ready=0 until return to IDLE.
- Assert rst during EXEC of req0 -> all outputs at reset values immediately (asynchronous); no rsp_valid; next request after release is granted normally.
- ALU_DIV0_GUARD_EN defined, req0 div 10/0 (sel 100) -> response one cycle after acceptance: result 0xFFFFFFFF, rsp_err=1, alu_* unchanged. Undefined: rsp_err=0, ALU path used.
